// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions and the hex glyph table.
// Glyphs are active-high gfedcba; polarity is applied by the driver.
package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high gfedcba segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner with PWM brightness, per-digit dp/blank and a
// double-buffered load handshake whose updates land only on frame boundaries.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BRIGHT_W       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [7:0]              digit,
  output logic [NUM_DIGITS-1:0]   select
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      ON_STEP   = CNT_W'(SCAN_DIV >> BRIGHT_W);
  localparam logic [7:0]            SEG_INV   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_INV   = SEL_ACTIVE_LOW ? '1 : '0;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] data;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      blank;
  } frame_t;

  localparam frame_t FRAME_DARK = '{data: '0, dp: '0, blank: '1};

  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic                  pend_full;
  frame_t                pend;
  frame_t                act;
  frame_t                load_frame;
  logic                  slot_last;
  logic                  frame_end;
  logic                  accept;
  logic                  lit;
  logic [CNT_W-1:0]      on_cycles;
  logic [6:0]            seg7;
  logic [7:0]            seg_on;
  logic [NUM_DIGITS-1:0] sel_on;

  assign load_frame = {load_data, load_dp, load_blank};
  assign load_ready = ~pend_full;
  assign accept     = load_valid & ~pend_full;
  assign slot_last  = (slot_cnt == SLOT_LAST);
  assign frame_end  = slot_last && (digit_idx == IDX_LAST);

  // Full brightness is special-cased: all-ones times the step falls one step short of the slot.
  assign on_cycles = CNT_W'(brightness) * ON_STEP;
  assign lit       = (brightness == '1) || (slot_cnt < on_cycles);

  seg7_hex_decode u_hex_decode (
    .nibble (act.data[digit_idx]),
    .seg    (seg7)
  );

  // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    seg_on = '0;
    sel_on = '0;
    if (lit) begin
      sel_on = NUM_DIGITS'(1) << digit_idx;
      if (!act.blank[digit_idx]) begin
        seg_on[SEG_G:SEG_A] = seg7;
        seg_on[SEG_DP]      = act.dp[digit_idx];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else begin
      slot_cnt <= slot_last ? '0 : slot_cnt + 1'b1;
      if (slot_last) begin
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end
    end
  end

  // Promotion and capture are mutually exclusive: capture needs pend_full low.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_full <= 1'b0;
      act       <= FRAME_DARK;
      digit     <= SEG_INV;
      select    <= SEL_INV;
    end else begin
      if (frame_end && pend_full) begin
        act       <= pend;
        pend_full <= 1'b0;
      end
      if (accept) begin
        pend_full <= 1'b1;
      end
      digit  <= seg_on ^ SEG_INV;
      select <= sel_on ^ SEL_INV;
    end
  end

  // NOTE: the pending payload has no reset; pend_full guards every read of it.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend <= load_frame;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized scoreboard bench for seg7_scan_driver; the reference model works from
// absolute cycle time since reset and a glyph table of its own.
module tb_seg7_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BW    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_dp = '0;
  logic [3:0]  load_blank = '0;
  logic [1:0]  brightness = 2'd3;
  logic [7:0]  digit;
  logic [3:0]  select;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .BRIGHT_W       (BW),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_blank (load_blank),
    .brightness (brightness),
    .digit      (digit),
    .select     (select)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

  typedef struct {
    logic [7:0] digit;
    logic [3:0] sel;
    logic       ready;
  } exp_t;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  int    t = 0;
  disp_t m_act;
  disp_t m_pend;
  bit    m_pend_full = 1'b0;
  bit    done = 1'b0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Reference model: outputs after an edge reflect the display state before that edge.
  task automatic model_edge();
    exp_t       e;
    int         pos, d, s, on;
    bit         lit;
    logic [7:0] seg;
    if (rst) begin
      e = '{digit: 8'hFF, sel: 4'hF, ready: 1'b1};
      m_act       = '{data: '0, dp: '0, blank: 4'hF};
      m_pend_full = 1'b0;
      t           = 0;
    end else begin
      pos = t % FRAME;
      d   = pos / SD;
      s   = pos % SD;
      on  = int'(brightness) * (SD >> BW);
      lit = (brightness == 2'd3) || (s < on);
      seg = 8'h00;
      if (lit && !m_act.blank[d])
        seg = {m_act.dp[d], glyph[m_act.data[d*4 +: 4]]};
      e.digit = ~seg;
      e.sel   = lit ? (4'hF ^ (4'b0001 << d)) : 4'hF;
      if (pos == FRAME - 1 && m_pend_full) begin
        m_act       = m_pend;
        m_pend_full = 1'b0;
      end else if (load_valid && !m_pend_full) begin
        m_pend      = '{data: load_data, dp: load_dp, blank: load_blank};
        m_pend_full = 1'b1;
      end
      e.ready = !m_pend_full;
      t++;
    end
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  // Monitor: compares each registered output set half a cycle after it appears.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!done && q.size() > 0) begin
      e = q.pop_front();
      check("digit", 32'(digit), 32'(e.digit));
      check("select", 32'(select), 32'(e.sel));
      check("load_ready", 32'(load_ready), 32'(e.ready));
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(logic [15:0] data, logic [3:0] dp, logic [3:0] blank);
    int k = 0;
    load_valid = 1'b1;
    load_data  = data;
    load_dp    = dp;
    load_blank = blank;
    while (!load_ready && k < 4 * FRAME) begin
      step();
      k++;
    end
    if (k == 4 * FRAME) check("accept_timeout", 0, 1);
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_pos(int p);
    int k = 0;
    while ((t % FRAME) != p && k < 2 * FRAME) begin
      step();
      k++;
    end
    if (k == 2 * FRAME) check("pos_timeout", 0, 1);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!load_ready && k < 4 * FRAME) begin
      step();
      k++;
    end
    if (k == 4 * FRAME) check("ready_timeout", 0, 1);
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    step(FRAME + 8);

    step($urandom_range(1, 10));
    offer(16'h1A30, 4'b0010, 4'b0000);
    step(3 * FRAME);

    offer(16'($urandom), 4'($urandom), 4'b0000);
    load_data  = 16'hBEEF;
    load_valid = 1'b1;
    step(6);
    load_valid = 1'b0;
    step(3 * FRAME);

    brightness = 2'd1;
    step(FRAME + 4);
    brightness = 2'd0;
    step(FRAME + 4);
    brightness = 2'd2;
    step(FRAME + 4);
    brightness = 2'd3;

    wait_ready();
    wait_pos(FRAME - 1);
    load_valid = 1'b1;
    load_data  = 16'h7C4D;
    load_dp    = 4'b1001;
    load_blank = 4'b0100;
    step();
    load_valid = 1'b0;
    step(3 * FRAME);

    wait_pos(2 * SD + 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(FRAME + 4);
    offer(16'($urandom), 4'($urandom), 4'($urandom));
    step(2 * FRAME);

    repeat (600) begin
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = 16'($urandom);
      load_dp    = 4'($urandom);
      load_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 31) == 0) brightness = 2'($urandom);
      step();
    end

    load_valid = 1'b0;
    step(3);
    @(negedge clk);
    #1;
    done = 1'b1;
    check("queue_drain", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver. Scans NUM_DIGITS common-select digits and decodes a hex nibble per digit. Adds per-digit decimal point and blanking, PWM brightness control, and a double-buffered load handshake so that display updates land only on frame boundaries. Sits between the processor/IO register block and the board pins `digit`/`select`, replacing the fixed 6-digit scanner.

Parameters:
- NUM_DIGITS, 6: number of scanned digits (1..16).
- SCAN_DIV, 50000: clock cycles per digit slot (>= 2^BRIGHT_W; must be a multiple of 2^BRIGHT_W).
- BRIGHT_W, 4: width of the brightness input.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs are driven low to light.
- SEL_ACTIVE_LOW, 1: 1 = select outputs are driven low to enable a digit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  new display contents offered.
- load_ready  out  1  pending buffer empty; a load is accepted when load_valid && load_ready.
- load_data  in  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i].
- load_dp  in  NUM_DIGITS  decimal point per digit.
- load_blank  in  NUM_DIGITS  1 = digit i is dark (segments and dp off).
- brightness  in  BRIGHT_W  0 = display off; all-ones = full on.
- digit  out  8  segments; [6:0] = g..a, [7] = dp; polarity per SEG_ACTIVE_LOW.
- select  out  NUM_DIGITS  one-hot digit enable; polarity per SEL_ACTIVE_LOW.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - digit and select go to inactive level (all 1s when active-low).
  - load_ready=1; pending buffer empty.
  - Active buffer: all digits blanked.
  - slot_cnt=0, digit_idx=0.
- Counters:
  - slot_cnt runs 0..SCAN_DIV-1 and wraps.
  - On wrap, digit_idx increments 0..NUM_DIGITS-1 and wraps to 0.
  - Frame boundary = the cycle with digit_idx==NUM_DIGITS-1 && slot_cnt==SCAN_DIV-1.
- Load handshake:
  - An accepted load is captured into the pending buffer; load_ready drops the next cycle.
  - At a frame boundary with pending full: pending is copied to active, and load_ready returns to 1 the next cycle.
  - New contents are first displayed on digit 0 of the next frame. No partial-frame tearing.
  - A load accepted in the same cycle as a frame boundary (pending empty) is held in pending and is not promoted until the following boundary.
  - load_valid while load_ready=0 is ignored; no data is captured.
  - Brightness is sampled live, not buffered.
- PWM:
  - on_cycles = brightness * (SCAN_DIV >> BRIGHT_W).
  - The digit is lit while slot_cnt < on_cycles.
  - brightness = all-ones lights the full slot (special case).
  - brightness = 0 keeps select inactive for the whole slot.
- Output:
  - digit and select are registered: 1-cycle latency from the counter/buffer state.
  - When lit, select is one-hot at digit_idx. Otherwise all select bits are inactive.
  - digit = hex decode of the nibble, with dp in bit 7.
  - A blanked digit drives all segments inactive. Its select still follows the scan (keeps timing uniform).
  - While select is inactive, digit is also driven inactive (anti-ghosting).
- Hex decode, active-high gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Output is inverted when SEG_ACTIVE_LOW=1.
- Reset mid-frame: counters restart at digit 0 and pending is discarded. Active is blanked; nothing is displayed until the next load is promoted.

Decomposition:
- Shared package seg7_pkg:
  - 16-entry hex-to-segment constant table.
  - Segment bit-index constants (SEG_A..SEG_G, SEG_DP).
- Sub-module seg7_hex_decode: purely combinational nibble-to-7-bit decoder, reused by other display blocks.
- Scan counters, buffers and PWM stay in seg7_scan_driver.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BRIGHT_W=2, both polarities active-low.
1. Reset, then no load, brightness=3 -> select=1111 and digit=FF for every cycle of a full frame (all digits blanked).
2. Load data=16'h1A30, dp=0010, blank=0000, brightness=3 -> from the first post-boundary frame:
   - digit 0 = ~3F (0xC0), digit 1 = ~CF (0x30, dp on), digit 2 = ~77 (0x88), digit 3 = ~06 (0xF9).
   - select cycles 1110, 1101, 1011, 0111, each held 8 cycles.
3. Load accepted mid-frame, then a second load_valid -> load_ready=0 until the boundary; the second offer is ignored. Old contents finish the frame; new contents start at digit 0.
4. brightness=1 -> each slot: select active for 2 cycles, inactive for 6 (digit=FF). brightness=0 -> select=1111 throughout.
5. load_valid asserted exactly on the boundary cycle -> the data is displayed only from the frame after next; load_ready=0 across the intervening frame.
6. rst pulsed for 1 cycle mid-slot on digit 2 -> next cycle select=1111 and digit=FF, load_ready=1. Scanning restarts at digit 0 with slot_cnt=0.
